// File: rtl/hmmm_pkg.sv
// Shared definitions for the HMMM core and its memory-side responder:
// datapath widths and the responder's load/clear/run state encoding.
package hmmm_pkg;

   localparam int INSTR_W = 10;
   localparam int DATA_W  = 4;
   localparam int ADDR_W  = 8;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2
   } resp_state_t;

endpackage

// File: rtl/mem_array.sv
// Generic storage array: one synchronous write port, one combinational read port.
module mem_array #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset; contents are only defined once written,
   // which lets this map onto RAM macros instead of a flop-per-bit array.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hmmm_mem_responder.sv
// Memory responder for the HMMM core: streams a program image into imem,
// zeroes dmem, then serves zero-latency fetches and loads/stores to the core.
module hmmm_mem_responder
   import hmmm_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] instruct,
   input  logic [ADDR_W-1:0]  adr,
   input  logic               memWrite,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  ReadData,
   output logic               cpu_reset,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [INSTR_W-1:0] ld_data,
   input  logic               ld_last,
   input  logic               ld_start,
   output logic [ADDR_W:0]    loaded_words
);

   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam logic [IAW-1:0]  IMEM_LAST = IAW'(IMEM_DEPTH - 1);
   localparam logic [DAW-1:0]  DMEM_LAST = DAW'(DMEM_DEPTH - 1);
   localparam logic [ADDR_W:0] IMEM_LIM  = (ADDR_W + 1)'(IMEM_DEPTH);
   localparam logic [ADDR_W:0] DMEM_LIM  = (ADDR_W + 1)'(DMEM_DEPTH);

   resp_state_t        state;
   logic [IAW-1:0]     cnt;
   logic [DAW-1:0]     clr_idx;

   logic               run;
   logic               pc_ok;
   logic               adr_ok;
   logic               imem_we;
   logic [INSTR_W-1:0] imem_rdata;
   logic               dmem_we;
   logic [DAW-1:0]     dmem_waddr;
   logic [DATA_W-1:0]  dmem_wdata;
   logic [DATA_W-1:0]  dmem_rdata;

   assign run       = (state == S_RUN);
   assign pc_ok     = ({1'b0, pc} < IMEM_LIM);
   assign adr_ok    = ({1'b0, adr} < DMEM_LIM);
   assign ld_ready  = (state == S_LOAD) & ~reset;
   assign cpu_reset = ~run | reset;
   assign imem_we   = ld_ready & ld_valid;

   assign instruct  = (run && pc_ok)  ? imem_rdata : '0;
   assign ReadData  = (run && adr_ok) ? dmem_rdata : '0;

   // dmem write port is shared between the clear sweep and core stores.
   always_comb begin
      // NOTE: every output gets a default before the case so no path
      // leaves a signal unassigned and infers a latch.
      dmem_we    = 1'b0;
      dmem_waddr = adr[DAW-1:0];
      dmem_wdata = wdata;
      case (state)
         S_CLEAR: begin
            dmem_we    = ~reset;
            dmem_waddr = clr_idx;
            dmem_wdata = '0;
         end
         S_RUN:   dmem_we = memWrite & adr_ok & ~reset;
         default: dmem_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      if (reset) begin
         state        <= S_LOAD;
         cnt          <= '0;
         clr_idx      <= '0;
         loaded_words <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (ld_valid) begin
                  cnt          <= cnt + 1'b1;
                  loaded_words <= (ADDR_W + 1)'(cnt) + 1'b1;
                  if (ld_last || cnt == IMEM_LAST) begin
                     state   <= S_CLEAR;
                     clr_idx <= '0;
                  end
               end
            end
            S_CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == DMEM_LAST) state <= S_RUN;
            end
            S_RUN: begin
               if (ld_start) begin
                  state <= S_LOAD;
                  cnt   <= '0;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

   mem_array #(.WIDTH(INSTR_W), .DEPTH(IMEM_DEPTH)) u_imem (
      .clk   (clk),
      .we    (imem_we),
      .waddr (cnt),
      .wdata (ld_data),
      .raddr (pc[IAW-1:0]),
      .rdata (imem_rdata)
   );

   mem_array #(.WIDTH(DATA_W), .DEPTH(DMEM_DEPTH)) u_dmem (
      .clk   (clk),
      .we    (dmem_we),
      .waddr (dmem_waddr),
      .wdata (dmem_wdata),
      .raddr (adr[DAW-1:0]),
      .rdata (dmem_rdata)
   );

endmodule

// File: tb/tb_hmmm_mem_responder.sv
// Directed bench for hmmm_mem_responder: load, clear timing, run-time
// fetch/store, reload, full-depth load and reset during clear.
module tb_hmmm_mem_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pc;
   logic [9:0] instruct;
   logic [7:0] adr;
   logic       memWrite;
   logic [3:0] wdata;
   logic [3:0] ReadData;
   logic       cpu_reset;
   logic       ld_valid;
   logic       ld_ready;
   logic [9:0] ld_data;
   logic       ld_last;
   logic       ld_start;
   logic [8:0] loaded_words;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hmmm_mem_responder #(.IMEM_DEPTH(256), .DMEM_DEPTH(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .instruct     (instruct),
      .adr          (adr),
      .memWrite     (memWrite),
      .wdata        (wdata),
      .ReadData     (ReadData),
      .cpu_reset    (cpu_reset),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_last      (ld_last),
      .ld_start     (ld_start),
      .loaded_words (loaded_words)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_word(input logic [9:0] data, input logic last);
      ld_valid = 1'b1;
      ld_data  = data;
      ld_last  = last;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pc = '0; adr = '0; memWrite = 1'b0; wdata = '0;
      ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; ld_start = 1'b0;
      @(negedge clk);
      step();

      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_ld_ready", ld_ready, 0);
      check("rst_instruct", instruct, 0);
      check("rst_readdata", ReadData, 0);
      check("rst_loaded_words", loaded_words, 0);

      reset = 1'b0;
      #1;
      check("load_ready", ld_ready, 1);

      load_word(10'h101, 1'b0);
      check("load_cnt1", loaded_words, 1);

      // Stall with ld_last high but no valid: nothing may be accepted.
      ld_last = 1'b1; ld_data = 10'h3AA;
      repeat (4) step();
      ld_last = 1'b0;
      check("stall_cnt", loaded_words, 1);
      check("stall_ready", ld_ready, 1);
      check("stall_cpu_reset", cpu_reset, 1);

      load_word(10'h2A5, 1'b0);
      check("load_ready_mid", ld_ready, 1);
      load_word(10'h3FF, 1'b1);
      check("load_cnt3", loaded_words, 3);
      check("clear_ready", ld_ready, 0);

      repeat (15) step();
      check("clear_cpu_reset_15", cpu_reset, 1);
      step();
      check("run_cpu_reset_16", cpu_reset, 0);

      pc = 8'd1; #1; check("fetch_pc1", instruct, 10'h2A5);
      pc = 8'd0; #1; check("fetch_pc0", instruct, 10'h101);
      pc = 8'd2; #1; check("fetch_pc2", instruct, 10'h3FF);

      adr = 8'd3; #1; check("dmem3_cleared", ReadData, 0);
      memWrite = 1'b1; wdata = 4'h7;
      #1; check("store_not_early", ReadData, 0);
      step();
      memWrite = 1'b0;
      check("store_adr3", ReadData, 4'h7);

      adr = 8'h40; memWrite = 1'b1; wdata = 4'hF;
      step();
      memWrite = 1'b0;
      check("oob_read", ReadData, 0);
      adr = 8'd0; #1; check("oob_no_alias", ReadData, 0);
      adr = 8'd3; #1; check("oob_keep3", ReadData, 4'h7);

      adr = 8'd5; memWrite = 1'b1; wdata = 4'hA;
      step();
      memWrite = 1'b0;
      check("prefill_adr5", ReadData, 4'hA);

      // Reload request together with a store.
      adr = 8'd6; memWrite = 1'b1; wdata = 4'h9; ld_start = 1'b1;
      step();
      memWrite = 1'b0; ld_start = 1'b0;
      check("reload_cpu_reset", cpu_reset, 1);
      check("reload_ready", ld_ready, 1);
      check("reload_readdata", ReadData, 0);
      check("reload_instruct", instruct, 0);

      load_word(10'h155, 1'b1);
      check("reload_cnt", loaded_words, 1);
      repeat (16) step();
      check("reload_run", cpu_reset, 0);
      adr = 8'd5; #1; check("reload_dmem5_zero", ReadData, 0);
      adr = 8'd6; #1; check("reload_dmem6_zero", ReadData, 0);
      pc = 8'd0; #1; check("reload_pc0", instruct, 10'h155);
      pc = 8'd1; #1; check("reload_pc1_kept", instruct, 10'h2A5);

      // Full-depth load without ld_last.
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      for (int i = 0; i < 255; i++) load_word(10'(i * 3 + 1), 1'b0);
      check("full_cnt255", loaded_words, 255);
      check("full_ready255", ld_ready, 1);
      load_word(10'(255 * 3 + 1), 1'b0);
      check("full_cnt256", loaded_words, 256);
      check("full_clear", ld_ready, 0);

      // Seven clear cycles, then reset with the clear index at 7.
      repeat (7) step();
      check("clear7_cpu_reset", cpu_reset, 1);
      pc = 8'd0; #1; check("clear_instruct0", instruct, 0);
      reset = 1'b1;
      #1;
      check("reset_ready_low", ld_ready, 0);
      step();
      reset = 1'b0;
      #1;
      check("post_rst_ready", ld_ready, 1);
      check("post_rst_cpu_reset", cpu_reset, 1);
      check("post_rst_loaded", loaded_words, 0);

      load_word(10'h0AB, 1'b1);
      check("final_cnt", loaded_words, 1);
      repeat (16) step();
      check("final_run", cpu_reset, 0);
      pc = 8'd0;   #1; check("final_pc0", instruct, 10'h0AB);
      pc = 8'd1;   #1; check("final_pc1", instruct, 10'd4);
      pc = 8'd255; #1; check("final_pc255", instruct, 10'd766);
      adr = 8'd3;  #1; check("final_dmem3", ReadData, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hmmm_mem_responder.md
# hmmm_mem_responder

Memory-side responder for the 4-bit HMMM core: owns instruction and data storage, answers the core's fetch and load/store requests in the same cycle, and holds the core in reset while a program image is streamed in over a valid/ready load port. After loading it zeroes data memory, then releases the core and serves it until a new load is requested. It sits beside `top`, driving `instruct`/`ReadData` and consuming `adr`/`memWrite`.

## Interface
Parameters:
- IMEM_DEPTH, 256, instruction words (≤256, power of two)
- DMEM_DEPTH, 16, data nibbles (≤256, power of two)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- pc  in  8  core fetch address
- instruct  out  10  instruction at `pc`
- adr  in  8  core data address
- memWrite  in  1  core store strobe
- wdata  in  4  core store data
- ReadData  out  4  data at `adr`
- cpu_reset  out  1  hold-reset to core, active-high
- ld_valid  in  1  load word present
- ld_ready  out  1  responder accepts load word
- ld_data  in  10  load word
- ld_last  in  1  final word of image, qualified by ld_valid
- ld_start  in  1  one-cycle request to reload (honoured only in RUN)
- loaded_words  out  9  count of words accepted in the last load

## Operation
- States: LOAD, CLEAR, RUN (enum in package). Reset → LOAD, load counter 0, clear counter 0, loaded_words 0.
- LOAD: ld_ready=1; handshake = ld_valid & ld_ready at edge → imem[cnt]←ld_data, cnt++, loaded_words=cnt+1. Accepted word with ld_last=1, or accepted word at cnt=IMEM_DEPTH-1 → CLEAR. Unwritten imem words keep prior contents.
- CLEAR: ld_ready=0; one dmem word zeroed per cycle, index 0..DMEM_DEPTH-1; after index DMEM_DEPTH-1 is written → RUN.
- RUN: cpu_reset=0. instruct = imem[pc] when pc<IMEM_DEPTH else 0. ReadData = dmem[adr] when adr<DMEM_DEPTH else 0. memWrite=1 at edge with adr in range → dmem[adr]←wdata; out-of-range writes dropped. ld_start=1 → LOAD, counter reset to 0.
- Outside RUN: cpu_reset=1, instruct=0, ReadData=0, memWrite ignored.
- Reset values: cpu_reset=1, ld_ready=0 while reset asserted, instruct=0, ReadData=0, loaded_words=0.

## Timing
- Reads are combinational, zero latency (single-cycle core). Writes (load, clear, store) take effect at the clock edge and are visible to reads in the next cycle.
- Load throughput one word/cycle; ld_ready is a combinational decode of state, no dependency on ld_valid.
- Final load word accepted at edge N → CLEAR from N; RUN entered at edge N+DMEM_DEPTH; cpu_reset low in the cycle after edge N+DMEM_DEPTH.
- ld_start and memWrite in the same RUN cycle: store completes, then LOAD. ld_start outside RUN ignored.
- ld_last with ld_valid=0 ignored. IMEM_DEPTH-th word forces CLEAR even with ld_last=0.
- reset during LOAD/CLEAR/RUN: next state LOAD, counters 0; memory contents untouched (partial clear acceptable).

## Structure
- Package `hmmm_pkg`: state enum, INSTR_W=10, DATA_W=4, ADDR_W=8 constants; shared with core.
- Sub-module `mem_array` (parameterised width/depth, one sync write port, one async read port), instantiated twice: imem (10b) and dmem (4b). CLEAR and RUN write paths muxed onto the dmem write port in the top FSM.

## Test plan
- Reset, stream 3 words 0x101,0x2A5,0x3FF (last on 3rd) → ld_ready=1 throughout, loaded_words=3, cpu_reset low exactly 16 cycles after 3rd accept; pc=1 → instruct=0x2A5.
- Pre-fill dmem[5]=0xA via store, ld_start, reload 1 word → after CLEAR, adr=5 → ReadData=0.
- RUN: memWrite adr=3 wdata=0x7 → ReadData=0x7 next cycle at adr=3; memWrite adr=0x40 → no dmem change, adr=0x40 reads 0.
- Stall ld_valid low for 4 cycles mid-load → no spurious writes, count unchanged; ld_last with ld_valid=0 ignored.
- 256 words with ld_last never asserted → CLEAR after 256th accept, loaded_words=256.
- Assert reset during CLEAR (clear index 7) → LOAD next cycle, cpu_reset=1, ld_ready=1, loaded_words=0.
